demode_cfg_ctrl: RTL

DEMODE_CFG_CTRL -- requirements
Module: demode_cfg_ctrl

---
 rtl/demode_pkg.sv | 54 +++++
 rtl/demode_frame_parser.sv | 77 +++++++
 rtl/demode_cfg_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/demode_pkg.sv
// Shared constants for the demodulator configuration controller: UART frame layout,
// register address map, mode encodings, reset values and the FSM state types.
package demode_pkg;

  localparam logic [7:0] SYNC = 8'hA5;

  // Demodulator mode encodings
  localparam logic [2:0] ModeAm     = 3'd0;
  localparam logic [2:0] ModeFm     = 3'd1;
  localparam logic [2:0] ModeAsk    = 3'd2;
  localparam logic [2:0] ModeFsk    = 3'd3;
  localparam logic [2:0] ModePsk    = 3'd4;
  localparam logic [2:0] ModeBypass = 3'd5;

  // Register address map
  localparam logic [7:0] AddrMode    = 8'h01;
  localparam logic [7:0] AddrAskThr  = 8'h02;
  localparam logic [7:0] AddrFskThr  = 8'h03;
  localparam logic [7:0] AddrPskThr  = 8'h04;
  localparam logic [7:0] AddrCicRate = 8'h05;
  localparam logic [7:0] AddrFmShift = 8'h06;

  // Reset values
  localparam logic [2:0]  RstMode    = ModeAm;
  localparam logic [15:0] RstAskThr  = 16'h4000;
  localparam logic [15:0] RstFskThr  = 16'h0000;
  localparam logic [15:0] RstPskThr  = 16'h0000;
  localparam logic [7:0]  RstCicRate = 8'd16;
  localparam logic [3:0]  RstFmShift = 4'd5;

  typedef enum logic [2:0] {StIdle, StAddr, StDh, StDl, StChk} parse_state_e;
  typedef enum logic [1:0] {StRun, StFlush, StSettle} seq_state_e;

  function automatic logic [7:0] frame_chk(logic [7:0] addr, logic [7:0] dh, logic [7:0] dl);
    return addr ^ dh ^ dl;
  endfunction

  // Address known and payload within range for that register.
  function automatic logic cfg_legal(logic [7:0] addr, logic [15:0] data);
    logic legal;
    legal = 1'b0;
    case (addr)
      AddrMode:    legal = (data[2:0] <= ModeBypass);
      AddrAskThr,
      AddrFskThr,
      AddrPskThr,
      AddrFmShift: legal = 1'b1;
      AddrCicRate: legal = (data[7:0] != 8'd0);
      default:     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/demode_frame_parser.sv
// Byte-level frame parser: SYNC/ADDR/DH/DL/CHK sequencing, checksum and inter-byte
// timeout. Emits a combinational one-cycle strobe in the cycle the CHK byte arrives.
module demode_frame_parser
  import demode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        frm_stb,
  output logic        frm_ok,
  output logic        frm_tmo,
  output logic [7:0]  frm_addr,
  output logic [15:0] frm_data
);

  localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);

  parse_state_e    state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dh_q, dh_d;
  logic [7:0]      dl_q, dl_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            tmo;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dh_q    <= '0;
      dl_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      gap_q   <= gap_d;
    end
  end

  // Gap counter only runs mid-frame; any accepted byte restarts it.
  assign tmo = (state_q != StIdle) && !rx_valid && (gap_q == GapLast);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    if (state_q == StIdle || rx_valid) gap_d = '0;
    else                               gap_d = gap_q + GapW'(1);
    unique case (state_q)
      StIdle: if (rx_valid && rx_byte == SYNC) state_d = StAddr;
      StAddr: if (rx_valid) begin addr_d = rx_byte; state_d = StDh; end
      StDh:   if (rx_valid) begin dh_d = rx_byte;   state_d = StDl; end
      StDl:   if (rx_valid) begin dl_d = rx_byte;   state_d = StChk; end
      StChk:  if (rx_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (tmo) begin
      state_d = StIdle;
      gap_d   = '0;
    end
  end

  always_comb begin
    frm_stb  = (state_q == StChk) && rx_valid;
    frm_ok   = (rx_byte == frame_chk(addr_q, dh_q, dl_q));
    frm_tmo  = tmo;
    frm_addr = addr_q;
    frm_data = {dh_q, dl_q};
  end

endmodule

// File: rtl/demode_cfg_ctrl.sv
// Demodulator configuration controller: UART-framed register writes plus a
// flush/settle sequencer that mutes the datapath after mode or decimation changes.
module demode_cfg_ctrl
  import demode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned FLUSH_CYC   = 64,
  parameter int unsigned SETTLE_CYC  = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [2:0]  demode_mode,
  output logic [15:0] ask_thr,
  output logic [15:0] fsk_thr,
  output logic [15:0] psk_thr,
  output logic [7:0]  cic_rate,
  output logic [3:0]  fm_shift,
  output logic        dp_flush,
  output logic        out_mute,
  output logic        cfg_busy,
  output logic        frame_err
);

  localparam int unsigned CntMax = (FLUSH_CYC > SETTLE_CYC) ? FLUSH_CYC : SETTLE_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] FlushLast  = CntW'(FLUSH_CYC - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

  logic        frm_stb, frm_ok, frm_tmo;
  logic [7:0]  frm_addr;
  logic [15:0] frm_data;

  demode_frame_parser #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_parser (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .frm_stb (frm_stb),
    .frm_ok  (frm_ok),
    .frm_tmo (frm_tmo),
    .frm_addr(frm_addr),
    .frm_data(frm_data)
  );

  logic cfg_ok, seq_restart;

  assign cfg_ok      = frm_stb && frm_ok && cfg_legal(frm_addr, frm_data);
  assign seq_restart = cfg_ok && (frm_addr == AddrMode || frm_addr == AddrCicRate);

  // Configuration registers
  logic [2:0]  mode_q, mode_d;
  logic [15:0] ask_q, ask_d, fsk_q, fsk_d, psk_q, psk_d;
  logic [7:0]  cic_q, cic_d;
  logic [3:0]  fm_q, fm_d;
  logic        err_q, err_d;

  always_comb begin
    mode_d = mode_q;
    ask_d  = ask_q;
    fsk_d  = fsk_q;
    psk_d  = psk_q;
    cic_d  = cic_q;
    fm_d   = fm_q;
    err_d  = frm_tmo || (frm_stb && !cfg_ok);
    if (cfg_ok) begin
      case (frm_addr)
        AddrMode:    mode_d = frm_data[2:0];
        AddrAskThr:  ask_d  = frm_data;
        AddrFskThr:  fsk_d  = frm_data;
        AddrPskThr:  psk_d  = frm_data;
        AddrCicRate: cic_d  = frm_data[7:0];
        AddrFmShift: fm_d   = frm_data[3:0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= RstMode;
      ask_q  <= RstAskThr;
      fsk_q  <= RstFskThr;
      psk_q  <= RstPskThr;
      cic_q  <= RstCicRate;
      fm_q   <= RstFmShift;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      ask_q  <= ask_d;
      fsk_q  <= fsk_d;
      psk_q  <= psk_d;
      cic_q  <= cic_d;
      fm_q   <= fm_d;
      err_q  <= err_d;
    end
  end

  // Flush / settle sequencer
  seq_state_e      seq_q, seq_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flush_q, flush_d, mute_q, mute_d, busy_q, busy_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seq_q   <= StRun;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      mute_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      mute_q  <= mute_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    seq_d = seq_q;
    cnt_d = cnt_q;
    unique case (seq_q)
      StRun: seq_d = StRun;
      StFlush: begin
        if (cnt_q == FlushLast) begin
          seq_d = StSettle;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          seq_d = StRun;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        seq_d = StRun;
        cnt_d = '0;
      end
    endcase
    // A new mode/rate write always restarts a full flush, whatever the current phase.
    if (seq_restart) begin
      seq_d = StFlush;
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they leave the flops aligned with seq_q.
  always_comb begin
    flush_d = (seq_d == StFlush);
    mute_d  = (seq_d != StRun);
    busy_d  = (seq_d != StRun);
  end

  assign demode_mode = mode_q;
  assign ask_thr     = ask_q;
  assign fsk_thr     = fsk_q;
  assign psk_thr     = psk_q;
  assign cic_rate    = cic_q;
  assign fm_shift    = fm_q;
  assign dp_flush    = flush_q;
  assign out_mute    = mute_q;
  assign cfg_busy    = busy_q;
  assign frame_err   = err_q;

endmodule
